link_stat_fsm: RTL and testbench

- Downstream consumer of the rxd frequency detector's three flags: lock_stat (1 MHz seen), pulse_err and phaselock_brk.
- Debounces each flag and runs a link supervision state machine.
- Latches the first fault cause and keeps saturating fault statistics.
- Drives the VCU link-health status used by the control logic.

---
 rtl/link_stat_pkg.sv | 30 +++
 rtl/deb_filter.sv | 39 +++
 rtl/link_stat_fsm.sv | 152 +++++++++++++++
 tb/tb_link_stat_fsm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/link_stat_pkg.sv
// link_stat_pkg: shared definitions for the link supervision block.
//   - link_state_t : 3-bit link state codes seen on link_state
//   - FC_*         : first-fault cause codes seen on fault_code ({err, brk})
//   - CNT_W/STAT_W : debounce/timer counter width and statistics width
//   - sat_inc      : saturating increment used by the fault statistics
package link_stat_pkg;

   localparam int CNT_W  = 16;
   localparam int STAT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACQUIRE  = 3'd1,
      ST_LOCKED   = 3'd2,
      ST_DEGRADED = 3'd3,
      ST_FAULT    = 3'd4
   } link_state_t;

   localparam logic [1:0] FC_NONE = 2'b00;
   localparam logic [1:0] FC_BRK  = 2'b01;
   localparam logic [1:0] FC_ERR  = 2'b10;
   localparam logic [1:0] FC_BOTH = 2'b11;

   // Increment by one when en is set, sticking at all-ones.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                 input logic              en);
      return (en && (v != '1)) ? v + STAT_W'(1) : v;
   endfunction

endpackage

// File: rtl/deb_filter.sv
// deb_filter: single-flag debouncer.
// The filtered output follows the raw input only after DEB_CYC consecutive
// samples disagree with it; any agreeing sample restarts the count.
// Ports:
//   clk_20M - 20 MHz clock
//   clr     - asynchronous active-high reset (dout and counter to 0)
//   din     - raw flag, synchronous to clk_20M
//   dout    - filtered flag
module deb_filter
   import link_stat_pkg::*;
#(
   parameter int DEB_CYC = 20
) (
   input  logic clk_20M,
   input  logic clr,
   input  logic din,
   output logic dout
);

   localparam logic [CNT_W-1:0] LIM = CNT_W'(DEB_CYC - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_20M or posedge clr) begin
      if (clr) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (din == dout) begin
         cnt <= '0;
      end else if (cnt == LIM) begin
         // DEB_CYC-th mismatching sample: accept the new level
         dout <= din;
         cnt  <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/link_stat_fsm.sv
// link_stat_fsm: link supervision for the rxd frequency detector flags.
// Debounces lock_stat/pulse_err/phaselock_brk, runs the IDLE/ACQUIRE/LOCKED/
// DEGRADED/FAULT state machine, latches the first fault cause and keeps
// saturating fault statistics.
// Optional build macro: LINK_STAT_IRQ_EN enables the link_irq event pulse;
// without it link_irq is constant 0.
// Ports:
//   clk_20M       - 20 MHz clock
//   clr           - asynchronous active-high reset
//   lock_stat     - 1 MHz lock flag
//   pulse_err     - out-of-band pulse flag
//   phaselock_brk - wire-break flag
//   fault_clr     - single-cycle fault acknowledge
//   link_state    - state code (IDLE=0 .. FAULT=4)
//   link_ok       - high only in LOCKED
//   fault_code    - first fault cause {err, brk}
//   err_cnt       - saturating count of FAULT entries with pulse error
//   brk_cnt       - saturating count of FAULT entries with break
//   link_irq      - one-cycle event pulse (FAULT entry / LOCKED exit)
module link_stat_fsm
   import link_stat_pkg::*;
#(
   parameter int DEB_CYC     = 20,
   parameter int LOCK_HOLD   = 2000,
   parameter int ACQ_TIMEOUT = 20000
) (
   input  logic              clk_20M,
   input  logic              clr,
   input  logic              lock_stat,
   input  logic              pulse_err,
   input  logic              phaselock_brk,
   input  logic              fault_clr,
   output logic [2:0]        link_state,
   output logic              link_ok,
   output logic [1:0]        fault_code,
   output logic [STAT_W-1:0] err_cnt,
   output logic [STAT_W-1:0] brk_cnt,
   output logic              link_irq
);

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(LOCK_HOLD - 1);
   localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(ACQ_TIMEOUT - 1);

   // flag order: [0] lock, [1] pulse error, [2] break
   logic [2:0] raw, filt;
   logic       lock_f, err_f, brk_f;

   assign raw    = {phaselock_brk, pulse_err, lock_stat};
   assign lock_f = filt[0];
   assign err_f  = filt[1];
   assign brk_f  = filt[2];

   for (genvar i = 0; i < 3; i++) begin : g_deb
      deb_filter #(.DEB_CYC(DEB_CYC)) u_deb (
         .clk_20M (clk_20M),
         .clr     (clr),
         .din     (raw[i]),
         .dout    (filt[i])
      );
   end

   link_state_t      state;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] to_cnt;

   assign link_state = state;

   always_ff @(posedge clk_20M or posedge clr) begin
      if (clr) begin
         state      <= ST_IDLE;
         link_ok    <= 1'b0;
         fault_code <= FC_NONE;
         err_cnt    <= '0;
         brk_cnt    <= '0;
         hold_cnt   <= '0;
         to_cnt     <= '0;
      end else if ((state != ST_FAULT) && (brk_f || err_f)) begin
         // fault has priority over every other transition
         state      <= ST_FAULT;
         link_ok    <= 1'b0;
         fault_code <= {err_f, brk_f};
         err_cnt    <= sat_inc(err_cnt, err_f);
         brk_cnt    <= sat_inc(brk_cnt, brk_f);
         hold_cnt   <= '0;
         to_cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state    <= ST_ACQUIRE;
               hold_cnt <= '0;
               to_cnt   <= '0;
            end
            ST_ACQUIRE: begin
               // lock checked first so it wins a same-cycle timeout
               if (lock_f && (hold_cnt == HOLD_LIM)) begin
                  state   <= ST_LOCKED;
                  link_ok <= 1'b1;
               end else if (to_cnt == TO_LIM) begin
                  state <= ST_DEGRADED;
               end else begin
                  hold_cnt <= lock_f ? hold_cnt + CNT_W'(1) : '0;
                  to_cnt   <= to_cnt + CNT_W'(1);
               end
            end
            ST_LOCKED: begin
               if (!lock_f) begin
                  state   <= ST_DEGRADED;
                  link_ok <= 1'b0;
               end
            end
            ST_DEGRADED: begin
               if (lock_f) begin
                  state    <= ST_ACQUIRE;
                  hold_cnt <= '0;
                  to_cnt   <= '0;
               end
            end
            ST_FAULT: begin
               // acknowledge only honoured once both fault flags are clean
               if (fault_clr && !brk_f && !err_f) begin
                  state      <= ST_IDLE;
                  fault_code <= FC_NONE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               link_ok <= 1'b0;
            end
         endcase
      end
   end

`ifdef LINK_STAT_IRQ_EN
   // Event is seen the cycle after the state edge, so the pulse lands on the
   // following edge; a LOCKED->FAULT step is one event, hence one pulse.
   link_state_t prev_state;

   always_ff @(posedge clk_20M or posedge clr) begin
      if (clr) begin
         prev_state <= ST_IDLE;
         link_irq   <= 1'b0;
      end else begin
         prev_state <= state;
         link_irq   <= ((state == ST_FAULT) && (prev_state != ST_FAULT)) ||
                       ((prev_state == ST_LOCKED) && (state != ST_LOCKED));
      end
   end
`else
   assign link_irq = 1'b0;
`endif

endmodule

// File: tb/tb_link_stat_fsm.sv
// tb_link_stat_fsm: self-checking bench for link_stat_fsm.
// Directed vector table with hand-derived expectations, a break-fault
// saturation sequence, an asynchronous mid-ACQUIRE reset, and a random phase,
// with every cycle also compared against a behavioural model.
`timescale 1ns/1ps
module tb_link_stat_fsm;

   localparam int DEB  = 20;
   localparam int HOLD = 100;
   localparam int TMO  = 400;
`ifdef LINK_STAT_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   logic       clk_20M = 1'b0;
   logic       clr = 1'b1;
   logic       lock_stat = 1'b0, pulse_err = 1'b0, phaselock_brk = 1'b0, fault_clr = 1'b0;
   logic [2:0] link_state;
   logic       link_ok;
   logic [1:0] fault_code;
   logic [7:0] err_cnt, brk_cnt;
   logic       link_irq;

   int checks = 0;
   int errors = 0;

   always #25 clk_20M = ~clk_20M;

   link_stat_fsm #(.DEB_CYC(DEB), .LOCK_HOLD(HOLD), .ACQ_TIMEOUT(TMO)) dut (
      .clk_20M       (clk_20M),
      .clr           (clr),
      .lock_stat     (lock_stat),
      .pulse_err     (pulse_err),
      .phaselock_brk (phaselock_brk),
      .fault_clr     (fault_clr),
      .link_state    (link_state),
      .link_ok       (link_ok),
      .fault_code    (fault_code),
      .err_cnt       (err_cnt),
      .brk_cnt       (brk_cnt),
      .link_irq      (link_irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Debounce: a flag flips once the last DEB raw samples taken since its
   // previous flip all disagree with the current filtered value.
   bit [2:0] hist[$];
   int       m_last[3];
   bit       m_f[3];
   int       m_st;          // state code 0..4
   bit       m_ok, m_irq, m_ev;
   bit [1:0] m_fc;
   int       m_ec, m_bc;
   int       m_age;         // ACQUIRE cycles elapsed since entry
   int       m_run;         // consecutive ACQUIRE cycles with lock seen

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < 3; i++) begin m_last[i] = -1; m_f[i] = 1'b0; end
      m_st = 0; m_ok = 0; m_irq = 0; m_ev = 0; m_fc = 0;
      m_ec = 0; m_bc = 0; m_age = 0; m_run = 0;
   endtask

   task automatic model_step();
      bit [2:0] raw;
      bit       lk, er, bk, all;
      int       nst, n;
      raw = {phaselock_brk, pulse_err, lock_stat};
      lk = m_f[0]; er = m_f[1]; bk = m_f[2];
      nst = m_st;
      if (m_st != 4 && (er || bk)) begin
         nst  = 4;
         m_fc = {er, bk};
         if (er && m_ec < 255) m_ec++;
         if (bk && m_bc < 255) m_bc++;
      end else begin
         case (m_st)
            0: begin nst = 1; m_age = 0; m_run = 0; end
            1: begin
               m_age++;
               m_run = lk ? m_run + 1 : 0;
               if (lk && m_run >= HOLD) nst = 2;
               else if (m_age >= TMO) nst = 3;
            end
            2: if (!lk) nst = 3;
            3: if (lk) begin nst = 1; m_age = 0; m_run = 0; end
            default: if (fault_clr && !er && !bk) begin nst = 0; m_fc = 0; end
         endcase
      end
      m_irq = IRQ && m_ev;
      m_ev  = (nst == 4 && m_st != 4) || (m_st == 2 && nst != 2);
      m_st  = nst;
      m_ok  = (nst == 2);
      hist.push_back(raw);
      n = hist.size() - 1;
      for (int i = 0; i < 3; i++) begin
         if (n - m_last[i] >= DEB) begin
            all = 1'b1;
            for (int k = n - DEB + 1; k <= n; k++)
               if (hist[k][i] == m_f[i]) all = 1'b0;
            if (all) begin m_f[i] = ~m_f[i]; m_last[i] = n; end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_20M);
      model_step();
      @(negedge clk_20M);
      check("model", {9'd0, link_state, link_ok, fault_code, err_cnt, brk_cnt, link_irq},
            {9'd0, 3'(m_st), m_ok, m_fc, 8'(m_ec), 8'(m_bc), m_irq});
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit lk, er, bk, fc;
      int n;
      int st; bit ok; int fcode; int ec; int bc; bit irq;
   } vec_t;
   vec_t tbl[$];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected done before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      //                lk er bk fc  n    st ok fc ec bc irq
      tbl.push_back('{1, 0, 0, 0,   1,   1, 0, 0, 0, 0, 0});   // IDLE -> ACQUIRE
      tbl.push_back('{1, 0, 0, 0, 118,   1, 0, 0, 0, 0, 0});   // still holding
      tbl.push_back('{1, 0, 0, 0,   1,   2, 1, 0, 0, 0, 0});   // LOCKED at DEB+HOLD
      tbl.push_back('{0, 0, 0, 0,  10,   2, 1, 0, 0, 0, 0});   // short drop filtered
      tbl.push_back('{1, 0, 0, 0,   5,   2, 1, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,  20,   2, 1, 0, 0, 0, 0});   // filter flips now
      tbl.push_back('{0, 0, 0, 0,   1,   3, 0, 0, 0, 0, 0});   // DEGRADED at DEB+1
      tbl.push_back('{0, 0, 0, 0,   1,   3, 0, 0, 0, 0, IRQ}); // LOCKED exit event
      tbl.push_back('{0, 0, 0, 0,   3,   3, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0,  20,   3, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0,   1,   1, 0, 0, 0, 0, 0});   // back to ACQUIRE
      tbl.push_back('{0, 0, 0, 0, 399,   1, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,   1,   3, 0, 0, 0, 0, 0});   // timeout at TMO
      tbl.push_back('{1, 0, 0, 0, 120,   1, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0,   1,   2, 1, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 1, 0,  20,   2, 1, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 1, 0,   1,   4, 0, 3, 1, 1, 0});   // both faults at once
      tbl.push_back('{1, 0, 1, 0,   1,   4, 0, 3, 1, 1, IRQ}); // single pulse
      tbl.push_back('{1, 0, 1, 1,   1,   4, 0, 3, 1, 1, 0});   // ack ignored, flags high
      tbl.push_back('{1, 0, 1, 0,  25,   4, 0, 3, 1, 1, 0});
      tbl.push_back('{1, 0, 0, 0,  20,   4, 0, 3, 1, 1, 0});   // ack not remembered
      tbl.push_back('{1, 0, 0, 1,   1,   0, 0, 0, 1, 1, 0});   // ack honoured
      tbl.push_back('{1, 0, 0, 0,   1,   1, 0, 0, 1, 1, 0});

      // reset state while clr held, lock_stat already high
      clr = 1'b1; lock_stat = 1'b1;
      repeat (3) @(posedge clk_20M);
      @(negedge clk_20M);
      check("reset.vec", {link_state, link_ok, fault_code, err_cnt, brk_cnt, link_irq}, 23'd0);
      clr = 1'b0;
      model_reset();
      check("reset.state_after_release", link_state, 0);

      foreach (tbl[r]) begin
         lock_stat = tbl[r].lk; pulse_err = tbl[r].er;
         phaselock_brk = tbl[r].bk; fault_clr = tbl[r].fc;
         repeat (tbl[r].n) tick();
         check($sformatf("row%0d.state", r), link_state, tbl[r].st);
         check($sformatf("row%0d.ok", r), link_ok, tbl[r].ok);
         check($sformatf("row%0d.fcode", r), fault_code, tbl[r].fcode);
         check($sformatf("row%0d.err_cnt", r), err_cnt, tbl[r].ec);
         check($sformatf("row%0d.brk_cnt", r), brk_cnt, tbl[r].bc);
         check($sformatf("row%0d.irq", r), link_irq, tbl[r].irq);
      end
      fault_clr = 1'b0;

      // 300 forced break faults: brk_cnt must stick at 255
      for (int i = 0; i < 300; i++) begin
         phaselock_brk = 1'b1;
         repeat (DEB + 1) tick();
         check("sat.state", link_state, 4);
         check("sat.brk_cnt", brk_cnt, (i + 2 > 255) ? 255 : i + 2);
         phaselock_brk = 1'b0;
         repeat (DEB) tick();
         fault_clr = 1'b1;
         tick();
         fault_clr = 1'b0;
      end
      check("sat.final_brk", brk_cnt, 255);
      check("sat.final_err", err_cnt, 1);
      check("sat.final_state", link_state, 0);

      // asynchronous reset in the middle of ACQUIRE
      lock_stat = 1'b1;
      repeat (6) tick();
      check("clr.pre_state", link_state, 1);
      #10 clr = 1'b1;
      #1;
      check("clr.async_vec", {link_state, link_ok, fault_code, err_cnt, brk_cnt, link_irq}, 23'd0);
      @(posedge clk_20M);
      @(negedge clk_20M);
      clr = 1'b0;
      model_reset();

      // random phase against the model
      for (int s = 0; s < 250; s++) begin
         int len;
         len           = $urandom_range(1, 45);
         lock_stat     = ($urandom_range(0, 3) != 0);
         pulse_err     = ($urandom_range(0, 11) == 0);
         phaselock_brk = ($urandom_range(0, 11) == 0);
         for (int c = 0; c < len; c++) begin
            fault_clr = ($urandom_range(0, 7) == 0);
            tick();
         end
      end
      fault_clr = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
